// File: rtl/sata_fifo_wr_ctrl.sv
// Write-side control of the 8-entry gray-pointer CDC FIFO.
// Owns the binary write counter, publishes its gray image to the read
// domain, synchronizes the read gray pointer back and derives registered
// fill-level, high, full and ready flags (usable depth 7).
module sata_fifo_wr_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       wr_en,
  output logic [2:0] wr_addr,
  output logic [2:0] cnt_wr,
  input  logic [2:0] cnt_rd_async,
  output logic       full,
  output logic       high,
  output logic [2:0] level
);

  typedef enum logic [1:0] {
    ST_RESET   = 2'b00,
    ST_ACCEPT  = 2'b01,
    ST_BLOCKED = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_din_ready;
  logic       w_ready_nxt;

  logic [2:0] r_wr_bin;
  logic [2:0] r_cnt_wr;
  logic [2:0] r_level;
  logic       r_full;
  logic       r_high;
  logic [2:0] r_sync [SYNC_STAGES];

  logic       w_wr_en;
  logic [2:0] w_wr_bin_next;
  logic [2:0] w_rd_sync;
  logic [2:0] w_rd_bin;
  logic [2:0] w_lvl_n;

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  assign w_wr_en       = din_valid & r_din_ready;
  assign w_wr_bin_next = r_wr_bin + {2'b00, w_wr_en};
  assign w_rd_sync     = r_sync[SYNC_STAGES-1];
  assign w_rd_bin[2]   = w_rd_sync[2];
  assign w_rd_bin[1]   = w_rd_sync[2] ^ w_rd_sync[1];
  assign w_rd_bin[0]   = w_rd_bin[1] ^ w_rd_sync[0];
  assign w_lvl_n       = w_wr_bin_next - w_rd_bin;

  assign wr_en     = w_wr_en;
  assign wr_addr   = r_wr_bin;
  assign cnt_wr    = r_cnt_wr;
  assign din_ready = r_din_ready;
  assign full      = r_full;
  assign high      = r_high;
  assign level     = r_level;

  // Read-pointer synchronizer chain; the last stage feeds the status path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= cnt_rd_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Write pointer: binary slot address and its gray image, both registered
  // so the gray value crossing to the read domain flips one bit per write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bin <= '0;
      r_cnt_wr <= '0;
    end else begin
      r_wr_bin <= w_wr_bin_next;
      r_cnt_wr <= bin2gray(w_wr_bin_next);
    end
  end

  // Status flags from the post-write level against the synchronized read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      r_full  <= 1'b0;
      r_high  <= 1'b0;
    end else begin
      r_level <= w_lvl_n;
      r_full  <= (w_lvl_n == 3'd7);
      r_high  <= (w_lvl_n >= 3'd4);
    end
  end

  // Acceptance state register; ready is held as its own flop so it is
  // driven straight from a register rather than a state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET;
      r_din_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_din_ready <= w_ready_nxt;
    end
  end

  // Next acceptance state: blocked exactly while the projected level is 7.
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b0;
    case (r_state)
      ST_RESET, ST_ACCEPT, ST_BLOCKED: begin
        if (w_lvl_n == 3'd7) begin
          w_state_nxt = ST_BLOCKED;
          w_ready_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_ACCEPT;
          w_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sata_fifo_wr_ctrl.sv
// Directed bench for sata_fifo_wr_ctrl: table-driven fill sequence plus
// hand-written startup, wrap, drain, simultaneous-event and reset sequences.
module tb_sata_fifo_wr_ctrl;

  localparam int unsigned SS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_valid;
  logic       din_ready;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] cnt_wr;
  logic [2:0] cnt_rd_async;
  logic       full;
  logic       high;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  sata_fifo_wr_ctrl #(.SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .cnt_wr       (cnt_wr),
    .cnt_rd_async (cnt_rd_async),
    .full         (full),
    .high         (high),
    .level        (level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dv;
    logic       exp_we;
    logic [2:0] exp_addr;
    logic [2:0] exp_cnt;
    logic [2:0] exp_lvl;
    logic       exp_high;
    logic       exp_full;
    logic       exp_rdy;
  } vec_t;

  vec_t       tbl [8];
  logic [2:0] gtab [8];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic [2:0] lvl, input logic h,
                            input logic f, input logic r);
    chk3({tag, ".level"}, level, lvl);
    chk1({tag, ".high"}, high, h);
    chk1({tag, ".full"}, full, f);
    chk1({tag, ".din_ready"}, din_ready, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int wraps;
    logic [2:0] idx;

    gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
    gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;

    //            dv    we    addr  cnt     lvl   high  full  rdy
    tbl[0] = '{1'b1, 1'b1, 3'd0, 3'b001, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 3'd1, 3'b011, 3'd2, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 3'd2, 3'b010, 3'd3, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 3'd3, 3'b110, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 3'd4, 3'b111, 3'd5, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 3'd5, 3'b101, 3'd6, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 3'd6, 3'b100, 3'd7, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 3'd7, 3'b100, 3'd7, 1'b1, 1'b1, 1'b0};

    // Reset / startup with a producer already offering data
    rst_n = 1'b0;
    din_valid = 1'b1;
    cnt_rd_async = 3'b000;
    #1;
    tick(); tick();
    chk3("rst.cnt_wr", cnt_wr, 3'b000);
    chk3("rst.wr_addr", wr_addr, 3'd0);
    chk1("rst.wr_en", wr_en, 1'b0);
    chk_status("rst", 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("startup.wr_en_pre", wr_en, 1'b0);
    tick();
    chk_status("startup", 3'd0, 1'b0, 1'b0, 1'b1);
    chk3("startup.cnt_wr", cnt_wr, 3'b000);
    chk3("startup.wr_addr", wr_addr, 3'd0);

    // Wrap: one write, then one read step, waiting out the sync latency
    din_valid = 1'b0;
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      idx = 3'(i);
      din_valid = 1'b1;
      #1;
      chk1("wrap.wr_en", wr_en, 1'b1);
      chk3("wrap.wr_addr", wr_addr, idx);
      tick();
      din_valid = 1'b0;
      idx = 3'(i + 1);
      chk3("wrap.cnt_wr", cnt_wr, gtab[idx]);
      chk_status("wrap.w", 3'd1, 1'b0, 1'b0, 1'b1);
      if (cnt_wr == 3'b000) wraps++;
      cnt_rd_async = gtab[idx];
      for (int k = 0; k < int'(SS) + 1; k++) tick();
      chk_status("wrap.r", 3'd0, 1'b0, 1'b0, 1'b1);
    end
    n_checks++;
    if (wraps != 2) begin
      n_fail++;
      $display("FAIL wrap.count: got %0d expected 2", wraps);
    end

    // Fill from empty (both pointers at 0) with the vector table
    for (int i = 0; i < 8; i++) begin
      din_valid = tbl[i].dv;
      #1;
      chk1("fill.wr_en", wr_en, tbl[i].exp_we);
      chk3("fill.wr_addr", wr_addr, tbl[i].exp_addr);
      tick();
      chk3("fill.cnt_wr", cnt_wr, tbl[i].exp_cnt);
      chk_status("fill", tbl[i].exp_lvl, tbl[i].exp_high, tbl[i].exp_full, tbl[i].exp_rdy);
    end
    din_valid = 1'b0;

    // Drain release: one read step frees a slot exactly SS+1 edges later
    cnt_rd_async = 3'b001;
    for (int k = 0; k < int'(SS); k++) begin
      tick();
      chk_status("drain.early", 3'd7, 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk_status("drain.release", 3'd6, 1'b1, 1'b0, 1'b1);

    // Simultaneous write and synchronized read advance at level 6
    cnt_rd_async = 3'b011;
    for (int k = 0; k < int'(SS); k++) begin
      tick();
      chk_status("simul.wait", 3'd6, 1'b1, 1'b0, 1'b1);
    end
    din_valid = 1'b1;
    #1;
    chk1("simul.wr_en", wr_en, 1'b1);
    chk3("simul.wr_addr", wr_addr, 3'd7);
    tick();
    chk3("simul.cnt_wr", cnt_wr, 3'b000);
    chk_status("simul", 3'd6, 1'b1, 1'b0, 1'b1);
    chk3("simul2.wr_addr", wr_addr, 3'd0);
    tick();
    din_valid = 1'b0;
    chk3("simul2.cnt_wr", cnt_wr, 3'b001);
    chk_status("simul2", 3'd7, 1'b1, 1'b1, 1'b0);

    // Step read pointer two gray steps to reach level 5
    cnt_rd_async = 3'b010;
    tick();
    cnt_rd_async = 3'b110;
    for (int k = 0; k < int'(SS) + 2; k++) tick();
    chk_status("pre_rst", 3'd5, 1'b1, 1'b0, 1'b1);

    // Mid-operation reset between edges: outputs clear immediately
    din_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    cnt_rd_async = 3'b000;
    #1;
    chk3("midrst.cnt_wr", cnt_wr, 3'b000);
    chk3("midrst.wr_addr", wr_addr, 3'd0);
    chk1("midrst.wr_en", wr_en, 1'b0);
    chk_status("midrst", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    tick();
    chk_status("midrst.start", 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("refill.wr_en", wr_en, 1'b1);
      chk3("refill.wr_addr", wr_addr, tbl[i].exp_addr);
      tick();
      chk3("refill.cnt_wr", cnt_wr, tbl[i].exp_cnt);
      chk_status("refill", tbl[i].exp_lvl, tbl[i].exp_high, tbl[i].exp_full, tbl[i].exp_rdy);
    end
    din_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sata_fifo_wr_ctrl.md
# sata_fifo_wr_ctrl

Write-side control for the 8-pointer gray-coded clock-domain-crossing FIFO in the SATA Altera datapath. It accepts words through a valid/ready handshake and drives the RAM write address and strobe. It publishes the gray write pointer to the read domain and synchronizes the read domain's gray pointer back. It computes registered full, high and fill-level flags that are consistent with the read-side gray comparator (usable depth 7).

## Interface
- SYNC_STAGES, 2, number of flip-flops synchronizing cnt_rd_async (legal 2..4)
- clk  in  1  write-domain clock; sole clock of the block
- rst_n  in  1  asynchronous, active-low reset
- din_valid  in  1  producer offers a word this cycle
- din_ready  out  1  registered; block accepts a word this cycle
- wr_en  out  1  RAM write strobe = din_valid & din_ready (combinational)
- wr_addr  out  3  binary RAM slot for the current write (registered)
- cnt_wr  out  3  registered gray write pointer, sent to the read domain
- cnt_rd_async  in  3  gray read pointer from the read domain (asynchronous)
- full  out  1  registered; level = 7
- high  out  1  registered; level >= 4
- level  out  3  registered fill count (wr_bin - rd_bin) mod 8

## Operation
- Gray sequence (index 0..7): 000,001,011,010,110,111,101,100, then wrap to 000.
- Gray-to-binary conversion: b2=g2, b1=g2^g1, b0=b1^g0.
- Internal state: 3-bit binary write counter wr_bin, with wr_addr = wr_bin and cnt_wr = gray(wr_bin).
- Both wr_addr and cnt_wr are registers, never combinational decodes.
- A write occurs when wr_en=1. On that edge, wr_bin increments mod 8 and cnt_wr advances one gray step.
- Exactly one bit of cnt_wr changes per write. cnt_wr never glitches.
- cnt_rd_async is captured through a SYNC_STAGES-deep flop chain. The last stage is rd_sync, and rd_bin = bin(rd_sync).
- The status path is evaluated each cycle from wr_bin_next (wr_bin + wr_en) and rd_bin:
  - lvl_n = (wr_bin_next - rd_bin) mod 8
  - full <= (lvl_n == 7)
  - high <= (lvl_n >= 4)
  - level <= lvl_n
  - din_ready <= (lvl_n != 7)
- Flags agree with the read-side comparator: full when the write index equals the read index minus 1 (mod 8); empty on the read side at level 0.
- Flags are pessimistic. A read-pointer advance frees space only after synchronization, so full may stay high longer than necessary but never clears early. This guarantees no overwrite of unread data.
- No state machine beyond the pointer counter and status registers. Required state: ACCEPT (din_ready=1) and BLOCKED (din_ready=0), with:
  - ACCEPT -> BLOCKED when lvl_n reaches 7
  - BLOCKED -> ACCEPT when synchronized read progress makes lvl_n < 7

## Timing
- Reset (rst_n=0, asynchronous): cnt_wr=000, wr_addr=0, all sync stages=000, level=0, full=0, high=0, din_ready=0.
- The first rising edge after rst_n deasserts sets din_ready=1. No word is accepted during reset or on that first edge.
- Write latency:
  - wr_en and wr_addr are valid in the same cycle as the accepted word.
  - cnt_wr, level, full and high reflect that write after one edge.
- Read-pointer latency: a change sampled on cnt_rd_async at edge k is reflected in level/full/high/din_ready after edge k+SYNC_STAGES.
- Back-to-back writes at one per cycle are sustained until level reaches 7.
- The write that makes level 7 is accepted. din_ready is 0 on the following cycle.
- With din_valid=1 while din_ready=0, wr_en stays 0 and no pointer moves.
- Simultaneous write and synchronized read advance: level is unchanged, and full/high are recomputed from both.
- Wrap: wr_bin 7 -> 0 and cnt_wr 100 -> 000 on a write. Level arithmetic is mod 8 and stays correct across the wrap.
- Multi-bit changes on cnt_rd_async between edges are a protocol violation with undefined flags. The read side must be gray-stepped.
- Reset mid-operation:
  - Pointers and flags clear immediately and asynchronously.
  - An in-flight write is dropped.
  - The read domain must be reset in the same event.

## Test plan
- Reset/startup: hold rst_n=0 with din_valid=1 -> cnt_wr=000, din_ready=0, wr_en=0. One edge after release -> din_ready=1, level=0.
- Fill with cnt_rd_async=000 and 7 consecutive writes:
  - wr_addr sequence 0..6
  - cnt_wr sequence 001,011,010,110,111,101,100
  - high=1 from level 4
  - full=1 and din_ready=0 after the 7th write
  - 8th din_valid produces no wr_en
- Drain release: from full, change cnt_rd_async 000->001 -> full=0, din_ready=1, level=6 exactly SYNC_STAGES+1 edges later, and not before.
- Wrap: alternate one write and one read-pointer step for 20 cycles -> cnt_wr wraps 100->000 twice. Level stays within 0..1 and never flags full or high.
- Simultaneous events: at level 6, assert a write on the same edge the synchronized read pointer advances -> level stays 6 and full stays 0. A further write with no read -> full=1.
- Mid-operation reset: at level 5, pulse rst_n low between edges -> all outputs take reset values immediately. Refill proceeds correctly starting from wr_addr=0.
